// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiplier APB initiator.
// Holds the FSM state enum, the latched command record and the lane-count helper.
package matmul_pkg;

    localparam int BUS_WIDTH_DEF      = 32;
    localparam int DATA_WIDTH_DEF     = 8;
    localparam int ADDR_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    // One strobe bit per matrix element lane on the bus.
    function automatic int max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    localparam int MAX_DIM_DEF = max_dim(BUS_WIDTH_DEF, DATA_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                      write;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [BUS_WIDTH_DEF-1:0]  wdata;
        logic [MAX_DIM_DEF-1:0]    strb;
    } apb_cmd_t;

endpackage

// File: rtl/matmul_apb_master_if.sv
// Command/response port and APB bus of the matmul APB initiator, bundled as one interface.
// Signal names carry the initiator's point of view (_i in, _o out).
interface matmul_apb_master_if
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    localparam int MAX_DIM = max_dim(BUS_WIDTH, DATA_WIDTH);

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [BUS_WIDTH-1:0]  cmd_wdata_i;
    logic [MAX_DIM-1:0]    cmd_strb_i;

    logic                  rsp_valid_o;
    logic [BUS_WIDTH-1:0]  rsp_rdata_o;
    logic                  rsp_err_o;

    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [BUS_WIDTH-1:0]  pwdata_o;
    logic [MAX_DIM-1:0]    pstrb_o;
    logic                  pready_i;
    logic                  pslverr_i;
    logic [BUS_WIDTH-1:0]  prdata_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  pready_i, pslverr_i, prdata_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output pready_i, pslverr_i, prdata_i
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter with clear, enable and a terminal-count flag.
// tc_o is high in the enabled cycle whose increment reaches LIMIT (or beyond).
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/matmul_apb_master.sv
// APB initiator for the matmul accelerator: one command at a time through SETUP/ACCESS.
// Optional wait-state abort is enabled by defining MATMUL_APB_TIMEOUT_EN.
module matmul_apb_master
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                busy_i,
    output logic                timeout_o,
    matmul_apb_master_if.master bus
);
    apb_state_t           state_q, state_d;
    apb_cmd_t             cmd_q, cmd_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 cmd_ready;
    logic                 active;
    logic                 abort;

`ifdef MATMUL_APB_TIMEOUT_EN
    logic timeout_q;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == SETUP),
        .en_i   ((state_q == ACCESS) && !bus.pready_i),
        .tc_o   (abort)
    );

    // Sticky until reset; set on the same edge that leaves ACCESS by abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (abort) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign abort              = 1'b0;
    assign timeout_o          = 1'b0;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        cmd_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // busy_i only holds off writes; reads may still reach the slave.
                cmd_ready = !(bus.cmd_write_i && busy_i);
                if (bus.cmd_valid_i && cmd_ready) begin
                    cmd_d.write = bus.cmd_write_i;
                    cmd_d.addr  = bus.cmd_addr_i;
                    cmd_d.wdata = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
                    cmd_d.strb  = bus.cmd_write_i ? bus.cmd_strb_i  : '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr_i;
                    rsp_rdata_d = cmd_q.write ? '0 : bus.prdata_i;
                    state_d     = IDLE;
                end else if (abort) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Decoded straight from state_q so psel/penable fall with the async reset.
    assign active = (state_q != IDLE);

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.psel_o      = active;
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.pwrite_o    = active && cmd_q.write;
    assign bus.paddr_o     = active ? cmd_q.addr  : '0;
    assign bus.pwdata_o    = active ? cmd_q.wdata : '0;
    assign bus.pstrb_o     = active ? cmd_q.strb  : '0;

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: table of single transfers plus hand-written
// sequences for back-to-back issue, wait-state abort (MATMUL_APB_TIMEOUT_EN) and reset.
module tb_matmul_apb_master;

    localparam int BW  = 32;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy  = 1'b0;
    logic timeout;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    matmul_apb_master_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    matmul_apb_master #(
        .BUS_WIDTH      (BW),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .busy_i    (busy),
        .timeout_o (timeout),
        .bus       (bus)
    );

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        busy;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        bus.prdata_i    = '0;
    endtask

    task automatic check_bus(input string tag, input vec_t v, input logic pen);
        check({tag, "_psel"},    32'(bus.psel_o),      32'd1);
        check({tag, "_penable"}, 32'(bus.penable_o),   32'(pen));
        check({tag, "_pwrite"},  32'(bus.pwrite_o),    32'(v.write));
        check({tag, "_paddr"},   32'(bus.paddr_o),     32'(v.addr));
        check({tag, "_pwdata"},  bus.pwdata_o,         v.exp_pwdata);
        check({tag, "_pstrb"},   32'(bus.pstrb_o),     32'(v.exp_pstrb));
        check({tag, "_rspv"},    32'(bus.rsp_valid_o), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = v.write;
        bus.cmd_addr_i  = v.addr;
        bus.cmd_wdata_i = v.wdata;
        bus.cmd_strb_i  = v.strb;
        busy            = v.busy;
        #1;
        if (v.write && v.busy) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, "_ready_blocked"}, 32'(bus.cmd_ready_o), 32'd0);
                check({tag, "_psel_blocked"},  32'(bus.psel_o),      32'd0);
                @(negedge clk);
                #1;
            end
            busy = 1'b0;
            #1;
        end
        check({tag, "_ready"}, 32'(bus.cmd_ready_o), 32'd1);

        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        busy            = 1'b1;
        #1;
        check_bus({tag, "_setup"}, v, 1'b0);

        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            bus.pready_i  = (w == v.waits);
            bus.prdata_i  = (w == v.waits) ? v.prdata : (32'hBAD0_0000 | 32'(w));
            bus.pslverr_i = (w == v.waits) ? v.slverr : 1'b1;
            #1;
            check_bus($sformatf("%s_access%0d", tag, w), v, 1'b1);
        end

        @(negedge clk);
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = '0;
        busy          = 1'b0;
        #1;
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata_o,      v.exp_rdata);
        check({tag, "_rsp_err"},   32'(bus.rsp_err_o),   32'(v.exp_err));
        check({tag, "_rsp_psel"},  32'(bus.psel_o),      32'd0);
        check({tag, "_rsp_paddr"}, 32'(bus.paddr_o),     32'd0);
        check({tag, "_rsp_ready"}, 32'(bus.cmd_ready_o), 32'd1);

        @(negedge clk);
        #1;
        check({tag, "_rsp_pulse"}, 32'(bus.rsp_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{write:1'b1, addr:16'h0010, wdata:32'hA5A5_1234, strb:4'hF, waits:0,
                    prdata:32'h1111_2222, slverr:1'b0, busy:1'b0,
                    exp_pwdata:32'hA5A5_1234, exp_pstrb:4'hF, exp_rdata:32'h0, exp_err:1'b0};
        vecs[1] = '{write:1'b0, addr:16'h0020, wdata:32'hFFFF_FFFF, strb:4'hF, waits:3,
                    prdata:32'hDEAD_BEEF, slverr:1'b0, busy:1'b0,
                    exp_pwdata:32'h0, exp_pstrb:4'h0, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0};
        vecs[2] = '{write:1'b1, addr:16'h0030, wdata:32'h0000_00FF, strb:4'h1, waits:1,
                    prdata:32'h5555_AAAA, slverr:1'b0, busy:1'b1,
                    exp_pwdata:32'h0000_00FF, exp_pstrb:4'h1, exp_rdata:32'h0, exp_err:1'b0};
        vecs[3] = '{write:1'b0, addr:16'h0044, wdata:32'h0, strb:4'h0, waits:0,
                    prdata:32'h1234_5678, slverr:1'b0, busy:1'b1,
                    exp_pwdata:32'h0, exp_pstrb:4'h0, exp_rdata:32'h1234_5678, exp_err:1'b0};
        vecs[4] = '{write:1'b0, addr:16'h0050, wdata:32'h0, strb:4'h0, waits:2,
                    prdata:32'hCAFE_F00D, slverr:1'b1, busy:1'b0,
                    exp_pwdata:32'h0, exp_pstrb:4'h0, exp_rdata:32'hCAFE_F00D, exp_err:1'b1};
        vecs[5] = '{write:1'b1, addr:16'hFFFF, wdata:32'h8000_0001, strb:4'hA, waits:0,
                    prdata:32'h7777_7777, slverr:1'b1, busy:1'b0,
                    exp_pwdata:32'h8000_0001, exp_pstrb:4'hA, exp_rdata:32'h0, exp_err:1'b1};

        idle_inputs();
        #2;
        check("rst_psel",    32'(bus.psel_o),      32'd0);
        check("rst_penable", 32'(bus.penable_o),   32'd0);
        check("rst_paddr",   32'(bus.paddr_o),     32'd0);
        check("rst_rspv",    32'(bus.rsp_valid_o), 32'd0);
        check("rst_rdata",   bus.rsp_rdata_o,      32'd0);
        check("rst_timeout", 32'(timeout),         32'd0);
        check("rst_ready",   32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_write_i = 1'b1;
        busy            = 1'b1;
        #1;
        check("rst_ready_busy_wr", 32'(bus.cmd_ready_o), 32'd0);
        bus.cmd_write_i = 1'b0;
        busy            = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Back-to-back reads with zero wait states: one response every third cycle.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 16'h0080;
        bus.pready_i    = 1'b1;
        bus.prdata_i    = 32'h0BAD_F00D;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 10) bus.cmd_valid_i = 1'b0;
            #1;
            check($sformatf("b2b_c%0d_rspv", c), 32'(bus.rsp_valid_o), 32'((c % 3 == 0) && (c > 0)));
            check($sformatf("b2b_c%0d_psel", c), 32'(bus.psel_o),      32'(c % 3 != 0));
            if ((c % 3 == 0) && (c > 0))
                check($sformatf("b2b_c%0d_rdata", c), bus.rsp_rdata_o, 32'h0BAD_F00D);
        end
        idle_inputs();

`ifdef MATMUL_APB_TIMEOUT_EN
        begin
            int   n_acc;
            logic got;
            n_acc = 0;
            got   = 1'b0;
            @(negedge clk);
            bus.cmd_valid_i = 1'b1;
            bus.cmd_addr_i  = 16'h0060;
            #1;
            check("tmo_ready", 32'(bus.cmd_ready_o), 32'd1);
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                #1;
                if (bus.rsp_valid_o) got = 1'b1;
                else if (bus.psel_o && bus.penable_o) n_acc++;
            end
            check("tmo_rsp_seen",  32'(got),             32'd1);
            check("tmo_access_n",  32'(n_acc),           32'(TMO));
            check("tmo_rsp_err",   32'(bus.rsp_err_o),   32'd1);
            check("tmo_rsp_rdata", bus.rsp_rdata_o,      32'd0);
            check("tmo_psel",      32'(bus.psel_o),      32'd0);
            check("tmo_flag",      32'(timeout),         32'd1);
            @(negedge clk);
            #1;
            check("tmo_flag_sticky", 32'(timeout), 32'd1);
        end
`else
        check("no_tmo_flag", 32'(timeout), 32'd0);
`endif

        // Reset while in ACCESS: bus drops without a clock edge and no response follows.
        begin
            logic saw_rsp;
            saw_rsp = 1'b0;
            @(negedge clk);
            bus.cmd_valid_i = 1'b1;
            bus.cmd_addr_i  = 16'h0070;
            #1;
            check("rstx_ready", 32'(bus.cmd_ready_o), 32'd1);
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            @(negedge clk);
            #1;
            check("rstx_access_pen", 32'(bus.penable_o), 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check("rstx_psel_async",    32'(bus.psel_o),    32'd0);
            check("rstx_penable_async", 32'(bus.penable_o), 32'd0);
            check("rstx_paddr_async",   32'(bus.paddr_o),   32'd0);
            @(negedge clk);
            bus.pready_i = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                #1;
                if (bus.rsp_valid_o || bus.psel_o) saw_rsp = 1'b1;
            end
            check("rstx_no_rsp",  32'(saw_rsp),         32'd0);
            check("rstx_timeout", 32'(timeout),         32'd0);
            check("rstx_ready",   32'(bus.cmd_ready_o), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
